// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, and a constant-safe ceil(log2).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Host-side delivery bus of the UART receiver: word + status under valid/ready, plus overrun/busy flags.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_tick_gen.sv
// Fractional rate generator: one-clk tick pulses averaging RATE per second from a CLOCK_RATE clock.
// Combinational tick from the accumulator state; free-running, no backpressure.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 50000000,
    parameter int RATE       = 1843200
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = CLOG2(CLOCK_RATE) + 1;
    localparam logic [W-1:0] INC = W'(RATE);
    localparam logic [W-1:0] LIM = W'(CLOCK_RATE);

    logic [W-1:0] acc_q, acc_d, sum;

    // acc stays below LIM and INC <= LIM, so the sum never overflows W bits
    always_comb begin
        sum   = acc_q + INC;
        tick  = (sum >= LIM);
        acc_d = tick ? (sum - LIM) : sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled 2-of-3 majority UART receiver; word delivered 1 clk after the last stop-bit decision tick.
// Held word is never overwritten: a new word arriving while rx_valid&!rx_ready is dropped with an overrun pulse. UART_RX_PARITY_EN adds a parity bit.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    uart_rx_os_if.master   rx_if
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
        (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) ||
        BAUD_RATE * OVERSAMPLE > CLOCK_RATE) begin : g_bad_cfg
        $error("uart_rx_os: illegal parameter combination");
    end

    localparam int TCW = CLOG2(OVERSAMPLE);
    localparam int BCW = CLOG2(DATA_BITS + 1);
    localparam logic [TCW-1:0] TC_S0   = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_S1   = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] TC_S2   = TCW'(OVERSAMPLE / 2 + 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS);
    localparam logic           SC_LAST = 1'(STOP_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rxs, rxs_prev_q;
    logic                 tick;
    uart_state_e          state_q, state_d;
    logic [TCW-1:0]       tc_q, tc_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 fe_acc_q, fe_acc_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 maj, decide, wrap, done;
`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD == PAR_ODD);
    logic                 pe_acc_q, pe_acc_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rxs = sync_q[1];

    uart_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .RATE       (BAUD_RATE * OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        tc_d        = tc_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        fe_acc_d    = fe_acc_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
        done        = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_acc_d     = pe_acc_q;
        parity_err_d = parity_err_q;
`endif

        decide = tick && (tc_q == TC_S2);
        wrap   = tick && (tc_q == TC_LAST);
        // third sample is the live rxs on the decision tick
        maj    = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

        if (tick && state_q != ST_IDLE) begin
            tc_d = (tc_q == TC_LAST) ? '0 : tc_q + 1'b1;
            if (tc_q == TC_S0) s0_d = rxs;
            if (tc_q == TC_S1) s1_d = rxs;
        end

        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d  = ST_START;
                    tc_d     = '0;
                    fe_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    pe_acc_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (decide && maj) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (wrap && bit_cnt_d == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (decide) pe_acc_d = maj ^ (^shift_q) ^ ODD;
                if (wrap) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                if (decide) begin
                    if (!maj) fe_acc_d = 1'b1;
                    // leave mid-bit so the next start edge is caught on back-to-back frames
                    if (stop_cnt_q == SC_LAST) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end
                end
                if (wrap && stop_cnt_q != SC_LAST) stop_cnt_d = stop_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_valid_q && rx_if.rx_ready) rx_valid_d = 1'b0;
        if (done) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d   = shift_q;
                frame_err_d = fe_acc_d;
                rx_valid_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = pe_acc_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= 2'b11;
            rxs_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            tc_q        <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            fe_acc_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rxd};
            rxs_prev_q  <= rxs;
            state_q     <= state_d;
            tc_q        <= tc_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            fe_acc_q    <= fe_acc_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_acc_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            pe_acc_q     <= pe_acc_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
    assign rx_if.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 32 clk/bit; parity vectors follow UART_RX_PARITY_EN when defined.
module tb_uart_rx_os;

    localparam int BIT_CLK = 32;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;

    uart_rx_os_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_os #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .STOP_BITS  (1),
        .CLOCK_RATE (3200000),
        .BAUD_RATE  (100000),
        .PARITY_ODD (0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // running totals only; each step compares deltas against a snapshot
    int         acc_cnt = 0, valid_cycles = 0, ovr_cnt = 0, busy_seen = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_fe = 1'b0, last_pe = 1'b0;

    always @(negedge clk) begin
        if (rx_if.rx_valid) valid_cycles++;
        if (rx_if.rx_valid && rx_if.rx_ready) begin
            acc_cnt++;
            last_data = rx_if.rx_data;
            last_fe   = rx_if.frame_err;
            last_pe   = rx_if.parity_err;
        end
        if (rx_if.overrun) ovr_cnt++;
        if (rx_if.busy) busy_seen++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input logic g);
        for (int j = 0; j < BIT_CLK; j++) begin
            @(posedge clk);
            #1;
            rxd = v ^ (g && (j == 17 || j == 18));
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            rxd = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic g);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], g);
        if (PAR_EN) drive_bit(par, 1'b0);
        drive_bit(stop, 1'b0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_val;
        logic       glitch;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[7];
    int   b_acc, b_val, b_ovr, b_busy;

    task automatic snap();
        b_acc  = acc_cnt;
        b_val  = valid_cycles;
        b_ovr  = ovr_cnt;
        b_busy = busy_seen;
    endtask

    initial begin
        vecs[0] = '{"a5_8n1",    8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{"break_fe",  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"5a_vote",   8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[3] = '{"ff",        8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{"3c_par1",   8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, PAR_EN};
        vecs[5] = '{"3c_par0",   8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[6] = '{"07_par0",   8'h07, 1'b0, 1'b1, 1'b0, 8'h07, 1'b0, PAR_EN};

        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_valid",   rx_if.rx_valid,   0);
        chk("rst_rx_data",    rx_if.rx_data,    0);
        chk("rst_busy",       rx_if.busy,       0);
        chk("rst_overrun",    rx_if.overrun,    0);
        chk("rst_frame_err",  rx_if.frame_err,  0);
        chk("rst_parity_err", rx_if.parity_err, 0);
        rst = 1'b1;
        idle(20);

        rx_if.rx_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            snap();
            send_frame(vecs[k].data, vecs[k].par_bit, vecs[k].stop_val, vecs[k].glitch);
            idle(40);
            chk({vecs[k].name, "_words"},  acc_cnt - b_acc,      1);
            chk({vecs[k].name, "_data"},   last_data,            vecs[k].exp_data);
            chk({vecs[k].name, "_fe"},     last_fe,              vecs[k].exp_fe);
            chk({vecs[k].name, "_pe"},     last_pe,              vecs[k].exp_pe);
            chk({vecs[k].name, "_vcyc"},   valid_cycles - b_val, 1);
            chk({vecs[k].name, "_ovr"},    ovr_cnt - b_ovr,      0);
        end

        // 6-clk low glitch on idle line is a false start
        snap();
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1;
            rxd = 1'b0;
        end
        idle(100);
        chk("glitch_words",     acc_cnt - b_acc,           0);
        chk("glitch_vcyc",      valid_cycles - b_val,      0);
        chk("glitch_busy_seen", (busy_seen - b_busy) > 0,  1);
        chk("glitch_busy_end",  rx_if.busy,                0);

        // back-to-back with consumer stalled
        rx_if.rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        idle(40);
        chk("ovr_pulses",  ovr_cnt - b_ovr, 1);
        chk("ovr_held_v",  rx_if.rx_valid,  1);
        chk("ovr_held_d",  rx_if.rx_data,   8'h11);
        chk("ovr_no_acc",  acc_cnt - b_acc, 0);
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b1;
        idle(10);
        chk("ovr_acc_cnt",  acc_cnt - b_acc, 1);
        chk("ovr_acc_data", last_data,       8'h11);
        chk("ovr_v_clear",  rx_if.rx_valid,  0);
        chk("ovr_pulses2",  ovr_cnt - b_ovr, 1);

        // reset in the middle of a frame, with a word held
        rx_if.rx_ready = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        idle(20);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        chk("pre_rst_busy",  rx_if.busy,     1);
        chk("pre_rst_valid", rx_if.rx_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",  rx_if.rx_valid,   0);
        chk("arst_data",   rx_if.rx_data,    0);
        chk("arst_busy",   rx_if.busy,       0);
        chk("arst_fe",     rx_if.frame_err,  0);
        chk("arst_pe",     rx_if.parity_err, 0);
        chk("arst_ovr",    rx_if.overrun,    0);
        idle(4);
        rst = 1'b1;
        rx_if.rx_ready = 1'b1;
        idle(20);
        snap();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        idle(40);
        chk("post_rst_words", acc_cnt - b_acc, 1);
        chk("post_rst_data",  last_data,       8'h81);
        chk("post_rst_fe",    last_fe,         0);
        chk("post_rst_ovr",   ovr_cnt - b_ovr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Next-generation UART receiver: oversampled, majority-voted serial-to-parallel converter with configurable data width, stop bits and optional parity. Sits between the synchronized `rxd` pin and the host-side consumer, delivering each received word with its error status over a valid/ready handshake. It supersedes the fixed-format receiver for all new UART instances.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, 16: sample ticks per bit, even, legal 4..64.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `CLOCK_RATE`, 50000000: `clk` frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `PARITY_ODD`, 0: 0 = even, 1 = odd. Ignored unless parity is compiled in.

- `clk`  in  1  system clock.
- `rst`  in  1  **asynchronous, active-low** reset.
- `rxd`  in  1  raw serial input, idle high.
- `rx_data`  out  DATA_BITS  received word, LSB = first bit on the line.
- `rx_valid`  out  1  `rx_data` and status are valid.
- `rx_ready`  in  1  consumer accepts the word.
- `frame_err`  out  1  a stop bit was sampled 0. Qualified by `rx_valid`.
- `parity_err`  out  1  parity mismatch. Qualified by `rx_valid`.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `busy`  out  1  a frame is in progress (state != IDLE).

## Operation
- `rxd` passes through a 2-flop synchronizer reset to 1. All logic uses the synchronized value `rxs`.
- Tick generator: free-running phase accumulator, width `CLOG2(CLOCK_RATE)+1`. Each clk it adds `BAUD_RATE*OVERSAMPLE`. When the sum reaches `CLOCK_RATE` or more, it subtracts `CLOCK_RATE` and pulses `tick` for one clk.
- Per-bit tick counter `tc`, width `CLOG2(OVERSAMPLE)`, counts 0..OVERSAMPLE-1 on `tick` and wraps.
- Samples are taken at `tc` = OS/2-1, OS/2 and OS/2+1. The bit value is the 2-of-3 majority, decided at `tc` = OS/2+1.
- FSM states:
  - IDLE: on `rxs` 1→0, clear `tc` and go to START.
  - START: at the decision, majority 1 → IDLE (false start, nothing reported). Majority 0 → continue to DATA at wrap.
  - DATA: shift the majority bit in LSB-first. Bit counter width `CLOG2(DATA_BITS+1)`. After DATA_BITS bits → PARITY if compiled in, else STOP.
  - PARITY: compare the majority bit with the XOR of the data bits (inverted when `PARITY_ODD`=1) → STOP.
  - STOP: every stop-bit majority must be 1, otherwise latch `frame_err`. At the decision of the last stop bit, go to IDLE immediately, without waiting for the end of the bit, so back-to-back frames are tracked.
- Delivery, on the cycle after the last stop decision:
  - `rx_valid`=0, or `rx_valid`&`rx_ready` in that same cycle: load `rx_data`/`frame_err`/`parity_err` and set `rx_valid`.
  - Otherwise keep the held word and status, and pulse `overrun`.
- Words with a framing error, including break (all zero), are still delivered with `frame_err`=1.
- `rx_valid` clears on `rx_valid`&`rx_ready` unless a new word loads in the same cycle.
- Reset, including mid-frame: FSM → IDLE, counters 0, synchronizer 1. All outputs 0: `rx_data`, `rx_valid`, `frame_err`, `parity_err`, `overrun`, `busy`.

## Timing
- Pin-to-`rxs` latency: 2 clk. Start detection: 1 clk after `rxs` falls.
- `rx_valid` rises 1 clk after the tick on which the last stop bit is decided.
- `overrun` is high for exactly 1 clk per dropped word.
- `rx_ready` may be held high permanently. Throughput is one word per frame time with zero bubbles.
- Tolerated baud mismatch: ±(OS/2-1)/OS of one bit over a full frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state present and one parity bit per frame expected.
  - `parity_err` computed per `PARITY_ODD`.
- Undefined:
  - no PARITY state; the frame is start + data + stop.
  - `parity_err` tied to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - `CLOG2` function.
  - parity-mode constants, also used by the matching transmitter.
- Sub-module `uart_tick_gen`: phase accumulator, parameters CLOCK_RATE and RATE, output `tick`. Reused by the transmitter.

## Test plan
Unless noted: CLOCK_RATE=3200000, BAUD_RATE=100000, OVERSAMPLE=16, so one tick per 2 clk and 32 clk per bit.
- 8N1, send 0xA5 with `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` high 1 clk, both errors 0.
- Parity build, even, send 0x3C with parity bit 1 → `parity_err`=1 and `rx_data`=0x3C. With parity bit 0 → `parity_err`=0.
- 0x00 with stop bit 0 → `frame_err`=1, `rx_data`=0x00. A 6-clk low glitch on an idle line → no `rx_valid`, `busy` returns to 0.
- `rx_ready`=0, send 0x11 then 0x22 back-to-back:
  - 0x11 held.
  - `overrun` pulses once at the 0x22 completion.
  - asserting `rx_ready` then yields 0x11 only.
- Single-sample inversion at `tc`=OS/2 on every data bit of 0x5A → still 0x5A received (majority vote).
- Assert `rst`=0 mid-DATA of 0xFF → all outputs 0 immediately, even without a clk edge. After release, 0x81 is received cleanly.
